// File: rtl/regfile_wr32.sv
// Write side of the 32-entry register file: one-hot write decode, 31 storage
// registers (register 0 reads as zero) and a registered write acknowledge.
module regfile_wr32 #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             regWrite,
  input  logic [4:0]       write_reg,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] q00,
  output logic [WIDTH-1:0] q01,
  output logic [WIDTH-1:0] q02,
  output logic [WIDTH-1:0] q03,
  output logic [WIDTH-1:0] q04,
  output logic [WIDTH-1:0] q05,
  output logic [WIDTH-1:0] q06,
  output logic [WIDTH-1:0] q07,
  output logic [WIDTH-1:0] q08,
  output logic [WIDTH-1:0] q09,
  output logic [WIDTH-1:0] q10,
  output logic [WIDTH-1:0] q11,
  output logic [WIDTH-1:0] q12,
  output logic [WIDTH-1:0] q13,
  output logic [WIDTH-1:0] q14,
  output logic [WIDTH-1:0] q15,
  output logic [WIDTH-1:0] q16,
  output logic [WIDTH-1:0] q17,
  output logic [WIDTH-1:0] q18,
  output logic [WIDTH-1:0] q19,
  output logic [WIDTH-1:0] q20,
  output logic [WIDTH-1:0] q21,
  output logic [WIDTH-1:0] q22,
  output logic [WIDTH-1:0] q23,
  output logic [WIDTH-1:0] q24,
  output logic [WIDTH-1:0] q25,
  output logic [WIDTH-1:0] q26,
  output logic [WIDTH-1:0] q27,
  output logic [WIDTH-1:0] q28,
  output logic [WIDTH-1:0] q29,
  output logic [WIDTH-1:0] q30,
  output logic [WIDTH-1:0] q31,
  output logic             wr_ack,
  output logic [4:0]       wr_last
);

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic [WIDTH-1:0] regs_q [1:NREGS-1];
  logic [WIDTH-1:0] regs_d [1:NREGS-1];
  logic [NREGS-1:1] wr_en;
  logic             wr_ack_q, wr_ack_d;
  logic [AW-1:0]    wr_last_q, wr_last_d;

  // Decode is gated first by regWrite so an undriven write_reg cannot enable anything.
  always_comb begin
    wr_en = '0;
    for (int i = 1; i < NREGS; i++) begin
      wr_en[i] = regWrite && (write_reg == AW'(i));
    end
  end

  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = wr_en[i] ? writeData : regs_q[i];
    end
    wr_ack_d  = regWrite;
    wr_last_d = regWrite ? write_reg : wr_last_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      wr_ack_q  <= 1'b0;
      wr_last_q <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_ack_q  <= wr_ack_d;
      wr_last_q <= wr_last_d;
    end
  end

  assign q00     = '0;
  assign q01     = regs_q[1];
  assign q02     = regs_q[2];
  assign q03     = regs_q[3];
  assign q04     = regs_q[4];
  assign q05     = regs_q[5];
  assign q06     = regs_q[6];
  assign q07     = regs_q[7];
  assign q08     = regs_q[8];
  assign q09     = regs_q[9];
  assign q10     = regs_q[10];
  assign q11     = regs_q[11];
  assign q12     = regs_q[12];
  assign q13     = regs_q[13];
  assign q14     = regs_q[14];
  assign q15     = regs_q[15];
  assign q16     = regs_q[16];
  assign q17     = regs_q[17];
  assign q18     = regs_q[18];
  assign q19     = regs_q[19];
  assign q20     = regs_q[20];
  assign q21     = regs_q[21];
  assign q22     = regs_q[22];
  assign q23     = regs_q[23];
  assign q24     = regs_q[24];
  assign q25     = regs_q[25];
  assign q26     = regs_q[26];
  assign q27     = regs_q[27];
  assign q28     = regs_q[28];
  assign q29     = regs_q[29];
  assign q30     = regs_q[30];
  assign q31     = regs_q[31];
  assign wr_ack  = wr_ack_q;
  assign wr_last = wr_last_q;

endmodule

// File: tb/tb_regfile_wr32.sv
// Directed bench for regfile_wr32: a reference model of the register array
// plus a queue of expected write results popped after each clock edge.
module tb_regfile_wr32;

  localparam int unsigned W = 32;

  typedef struct {
    int unsigned  idx;
    logic [W-1:0] val;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         regWrite;
  logic [4:0]   write_reg;
  logic [W-1:0] writeData;
  logic [W-1:0] q_arr [32];
  logic         wr_ack;
  logic [4:0]   wr_last;

  logic [W-1:0] m [32];
  logic [4:0]   m_last;
  exp_t         sb_q [$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           ack_run;

  always #5 clk = ~clk;

  regfile_wr32 #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .resetn(resetn), .regWrite(regWrite), .write_reg(write_reg),
    .writeData(writeData),
    .q00(q_arr[0]),  .q01(q_arr[1]),  .q02(q_arr[2]),  .q03(q_arr[3]),
    .q04(q_arr[4]),  .q05(q_arr[5]),  .q06(q_arr[6]),  .q07(q_arr[7]),
    .q08(q_arr[8]),  .q09(q_arr[9]),  .q10(q_arr[10]), .q11(q_arr[11]),
    .q12(q_arr[12]), .q13(q_arr[13]), .q14(q_arr[14]), .q15(q_arr[15]),
    .q16(q_arr[16]), .q17(q_arr[17]), .q18(q_arr[18]), .q19(q_arr[19]),
    .q20(q_arr[20]), .q21(q_arr[21]), .q22(q_arr[22]), .q23(q_arr[23]),
    .q24(q_arr[24]), .q25(q_arr[25]), .q26(q_arr[26]), .q27(q_arr[27]),
    .q28(q_arr[28]), .q29(q_arr[29]), .q30(q_arr[30]), .q31(q_arr[31]),
    .wr_ack(wr_ack), .wr_last(wr_last)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = '0;
    m_last = '0;
    sb_q.delete();
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s_q%02d", tag, i), q_arr[i], m[i]);
  endtask

  // Drive one cycle, step the model, then compare ack/last and pop the scoreboard.
  task automatic do_cycle(input logic we, input logic [4:0] wr, input logic [W-1:0] wd,
                          input string tag);
    exp_t e;
    logic exp_ack;
    regWrite  = we;
    write_reg = wr;
    writeData = wd;
    exp_ack   = resetn && we;
    if (exp_ack) sb_q.push_back('{idx: int'(wr), val: (wr == 5'd0) ? '0 : wd});
    @(posedge clk);
    #1;
    if (!resetn) begin
      model_reset();
    end else if (we) begin
      if (wr != 5'd0) m[wr] = wd;
      m_last = wr;
    end
    check({tag, "_ack"}, W'(wr_ack), W'(exp_ack));
    check({tag, "_last"}, W'(wr_last), W'(m_last));
    if (exp_ack) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, W'(1), W'(0));
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s_q%02d", tag, e.idx), q_arr[e.idx], e.val);
      end
    end
  endtask

  initial begin
    model_reset();
    resetn    = 1'b0;
    regWrite  = 1'b0;
    write_reg = '0;
    writeData = '0;

    // 1: writes during reset are dropped; first write after release lands
    for (int c = 0; c < 3; c++) do_cycle(1'b1, 5'd5, 32'hDEADBEEF, "rst_hold");
    check_all("rst");
    resetn = 1'b1;
    do_cycle(1'b1, 5'd5, 32'hDEADBEEF, "rst_rel");
    check("rst_rel_q05", q_arr[5], 32'hDEADBEEF);

    // 2: walking write, back-to-back
    ack_run = 0;
    for (int r = 1; r < 32; r++) begin
      do_cycle(1'b1, 5'(r), 32'h1000_0000 + 32'(r), "walk");
      if (wr_ack === 1'b1) ack_run++;
    end
    check("walk_ack_run", W'(ack_run), W'(31));
    check_all("walk");

    // 3: write to register 0 is acknowledged and discarded
    do_cycle(1'b1, 5'd0, 32'hFFFFFFFF, "r0");
    check_all("r0");
    do_cycle(1'b0, 5'd3, 32'h0, "r0_after");

    // 4: idle cycles with wandering and undriven address/data
    for (int c = 0; c < 20; c++) begin
      if (c % 4 == 0) do_cycle(1'b0, 5'bx, 32'hx, "idle");
      else do_cycle(1'b0, 5'($urandom_range(0, 31)), $urandom, "idle");
    end
    check_all("idle");

    // 5: overwrite same register, then hold
    do_cycle(1'b1, 5'd7, 32'hA5A5A5A5, "ow1");
    do_cycle(1'b1, 5'd7, 32'h5A5A5A5A, "ow2");
    for (int c = 0; c < 3; c++) do_cycle(1'b0, 5'd9, 32'h0, "hold");
    check("hold_q07", q_arr[7], 32'h5A5A5A5A);
    check("hold_last", W'(wr_last), W'(7));
    check_all("hold");

    // 6: asynchronous reset dropped between edges while writing
    do_cycle(1'b1, 5'd12, 32'hCAFEF00D, "mid_wr");
    regWrite = 1'b1;
    #4;
    resetn = 1'b0;
    #1;
    model_reset();
    check("async_q12", q_arr[12], '0);
    check("async_ack", W'(wr_ack), '0);
    check("async_last", W'(wr_last), '0);
    check_all("async");
    do_cycle(1'b1, 5'd12, 32'hCAFEF00D, "async_hold");
    resetn = 1'b1;
    do_cycle(1'b1, 5'd12, 32'h12345678, "post_rst");
    do_cycle(1'b0, 5'd0, 32'h0, "post_idle");
    check_all("post");

    check("sb_drained", W'(sb_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
